// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder slice.
package ps2_scancode_decoder_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;

  // Active-low 7-segment pattern with every segment and the dp dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Consumer FSM encodings, also usable as plain legacy constants
  localparam logic [1:0] ST_IDLE_C = 2'd0;
  localparam logic [1:0] ST_POP_C  = 2'd1;
  localparam logic [1:0] ST_GAP_C  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_C,
    ST_POP  = ST_POP_C,
    ST_GAP  = ST_GAP_C
  } state_e;

endpackage

// File: rtl/ps2_scancode_decoder_hex7seg.sv
// One hex nibble to an active-low 7-segment digit (bits 7..1 = a..g, bit 0 = dp).
module hex7seg
  import ps2_scancode_decoder_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [7:0] seg
);

  // Glyph lookup; blank overrides the digit and the dp stays off
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (hex)
        4'h0:    seg = 8'h03;
        4'h1:    seg = 8'h9F;
        4'h2:    seg = 8'h25;
        4'h3:    seg = 8'h0D;
        4'h4:    seg = 8'h99;
        4'h5:    seg = 8'h49;
        4'h6:    seg = 8'h41;
        4'h7:    seg = 8'h1F;
        4'h8:    seg = 8'h01;
        4'h9:    seg = 8'h09;
        4'hA:    seg = 8'h11;
        4'hB:    seg = 8'hC1;
        4'hC:    seg = 8'h63;
        4'hD:    seg = 8'h85;
        4'hE:    seg = 8'h61;
        4'hF:    seg = 8'h71;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops set-2 scan codes from an upstream FIFO, tracks the held key and
// drives six hex digits (key code, its ASCII, and the press count).
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_ext,
  output logic       key_valid,
  output logic [7:0] key_count,
  output logic       ovf_err,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5
);

  state_e     state_q, state_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_count_q, key_count_d;
  logic       ovf_err_q, ovf_err_d;
  logic       same_key_s;

  // Pop strobe is masked by reset so a byte under reset stays in the FIFO
  assign nextdata_n = ~((state_q == ST_POP) && !rst);

  // Consumer FSM: one byte per IDLE/POP/GAP round so the FIFO pointer settles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign same_key_s = key_valid_q && (data == key_code_q) && (ext_pend_q == key_ext_q);

  // Byte decode: prefixes only arm flags, other bytes press/release the key
  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = key_valid_q;
    key_count_d = key_count_q;
    ovf_err_d   = ovf_err_q | overflow;
    if (state_q == ST_POP) begin
      if (data == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (data == SC_BREAK) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (!brk_pend_q) begin
          // A repeat of the held key is typematic and leaves everything alone
          if (!same_key_s) begin
            key_code_d  = data;
            key_ext_d   = ext_pend_q;
            key_valid_d = 1'b1;
            key_count_d = key_count_q + 8'd1;
          end else begin
            key_valid_d = key_valid_q;
          end
        end else begin
          // Release only counts when it names the held key exactly
          if (same_key_s) begin
            key_valid_d = 1'b0;
          end else begin
            key_valid_d = key_valid_q;
          end
        end
      end
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  // State and decode registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_count_q <= 8'h00;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      key_count_q <= key_count_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Set-2 to lowercase ASCII; extended codes never map
  always_comb begin
    key_ascii = 8'h00;
    if (key_ext_q) begin
      key_ascii = 8'h00;
    end else begin
      case (key_code_q)
        8'h1C: key_ascii = 8'h61;  8'h32: key_ascii = 8'h62;
        8'h21: key_ascii = 8'h63;  8'h23: key_ascii = 8'h64;
        8'h24: key_ascii = 8'h65;  8'h2B: key_ascii = 8'h66;
        8'h34: key_ascii = 8'h67;  8'h33: key_ascii = 8'h68;
        8'h43: key_ascii = 8'h69;  8'h3B: key_ascii = 8'h6A;
        8'h42: key_ascii = 8'h6B;  8'h4B: key_ascii = 8'h6C;
        8'h3A: key_ascii = 8'h6D;  8'h31: key_ascii = 8'h6E;
        8'h44: key_ascii = 8'h6F;  8'h4D: key_ascii = 8'h70;
        8'h15: key_ascii = 8'h71;  8'h2D: key_ascii = 8'h72;
        8'h1B: key_ascii = 8'h73;  8'h2C: key_ascii = 8'h74;
        8'h3C: key_ascii = 8'h75;  8'h2A: key_ascii = 8'h76;
        8'h1D: key_ascii = 8'h77;  8'h22: key_ascii = 8'h78;
        8'h35: key_ascii = 8'h79;  8'h1A: key_ascii = 8'h7A;
        8'h45: key_ascii = 8'h30;  8'h16: key_ascii = 8'h31;
        8'h1E: key_ascii = 8'h32;  8'h26: key_ascii = 8'h33;
        8'h25: key_ascii = 8'h34;  8'h2E: key_ascii = 8'h35;
        8'h36: key_ascii = 8'h36;  8'h3D: key_ascii = 8'h37;
        8'h3E: key_ascii = 8'h38;  8'h46: key_ascii = 8'h39;
        8'h29: key_ascii = 8'h20;  8'h5A: key_ascii = 8'h0D;
        default: key_ascii = 8'h00;
      endcase
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_valid = key_valid_q;
  assign key_count = key_count_q;
  assign ovf_err   = ovf_err_q;

  // Code and ASCII digits go dark with no key held; the count is always shown
  hex7seg u_seg0 (.hex(key_code_q[3:0]),  .blank(!key_valid_q), .seg(seg0));
  hex7seg u_seg1 (.hex(key_code_q[7:4]),  .blank(!key_valid_q), .seg(seg1));
  hex7seg u_seg2 (.hex(key_ascii[3:0]),   .blank(!key_valid_q), .seg(seg2));
  hex7seg u_seg3 (.hex(key_ascii[7:4]),   .blank(!key_valid_q), .seg(seg3));
  hex7seg u_seg4 (.hex(key_count_q[3:0]), .blank(1'b0),         .seg(seg4));
  hex7seg u_seg5 (.hex(key_count_q[7:4]), .blank(1'b0),         .seg(seg5));

endmodule
